// File: rtl/mem_stage_lsu.sv
// MEM stage: one-entry valid/ready register, load alignment/extension, ID forwarding and flush drain.
// Optional HI/LO pass-through is built only when MEM_HILO_EN is defined.
module mem_stage_lsu #(
  parameter int PC_W = 32,
  parameter int RA_W = 5,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [2:0]      ex_load_type,
  input  logic [1:0]      ex_addr_lo,
  input  logic            ex_rf_we,
  input  logic [RA_W-1:0] ex_rf_waddr,
  input  logic [XLEN-1:0] ex_result,
`ifdef MEM_HILO_EN
  input  logic            ex_hilo_we,
  input  logic [XLEN-1:0] ex_hi,
  input  logic [XLEN-1:0] ex_lo,
  output logic            wb_hilo_we,
  output logic [XLEN-1:0] wb_hi,
  output logic [XLEN-1:0] wb_lo,
`endif
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] wb_pc,
  output logic            wb_rf_we,
  output logic [RA_W-1:0] wb_rf_waddr,
  output logic [XLEN-1:0] wb_rf_wdata,
  output logic            fwd_we,
  output logic [RA_W-1:0] fwd_waddr,
  output logic [XLEN-1:0] fwd_wdata,
  output logic            fwd_pending
);

  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_WAIT, S_DRAIN} state_t;

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic [2:0]      load_type_q;
  logic [1:0]      addr_lo_q;
  logic            rf_we_q;
  logic [RA_W-1:0] rf_waddr_q;
  logic [XLEN-1:0] result_q;
`ifdef MEM_HILO_EN
  logic            hilo_we_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
`endif

  logic            accept;
  logic            ex_is_load;
  logic [7:0]      sel_b;
  logic [15:0]     sel_h;
  logic [XLEN-1:0] ld_data;

  assign in_ready   = (state == S_EMPTY) || ((state == S_HOLD) && out_ready);
  assign accept     = in_valid && in_ready && !flush;
  assign ex_is_load = (ex_load_type >= 3'd1) && (ex_load_type <= 3'd5);

  // Alignment uses the registered address bits of the instruction waiting in WAIT.
  always_comb begin
    sel_b = dmem_rdata[8*addr_lo_q +: 8];
    sel_h = dmem_rdata[16*addr_lo_q[1] +: 16];
    case (load_type_q)
      3'd1:    ld_data = {{(XLEN-8){sel_b[7]}}, sel_b};
      3'd2:    ld_data = {{(XLEN-8){1'b0}}, sel_b};
      3'd3:    ld_data = {{(XLEN-16){sel_h[15]}}, sel_h};
      3'd4:    ld_data = {{(XLEN-16){1'b0}}, sel_h};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_EMPTY;
      pc_q        <= '0;
      load_type_q <= '0;
      addr_lo_q   <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      result_q    <= '0;
`ifdef MEM_HILO_EN
      hilo_we_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
`endif
    end else if (flush) begin
      pc_q        <= '0;
      load_type_q <= '0;
      addr_lo_q   <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      result_q    <= '0;
`ifdef MEM_HILO_EN
      hilo_we_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
`endif
      // A response that lands in the flush cycle itself closes out the drain.
      if ((state == S_WAIT || state == S_DRAIN) && !dmem_rvalid)
        state <= S_DRAIN;
      else
        state <= S_EMPTY;
    end else if (accept) begin
      pc_q        <= ex_pc;
      load_type_q <= ex_load_type;
      addr_lo_q   <= ex_addr_lo;
      rf_we_q     <= ex_rf_we;
      rf_waddr_q  <= ex_rf_waddr;
      result_q    <= ex_result;
`ifdef MEM_HILO_EN
      hilo_we_q   <= ex_hilo_we;
      hi_q        <= ex_hi;
      lo_q        <= ex_lo;
`endif
      state       <= ex_is_load ? S_WAIT : S_HOLD;
    end else begin
      case (state)
        S_WAIT: if (dmem_rvalid) begin
          result_q <= ld_data;
          state    <= S_HOLD;
        end
        S_HOLD:  if (out_ready) state <= S_EMPTY;
        S_DRAIN: if (dmem_rvalid) state <= S_EMPTY;
        default: state <= S_EMPTY;
      endcase
    end
  end

  assign out_valid   = (state == S_HOLD);
  assign wb_pc       = pc_q;
  assign wb_rf_we    = rf_we_q;
  assign wb_rf_waddr = rf_waddr_q;
  assign wb_rf_wdata = result_q;
  assign fwd_we      = (state == S_HOLD) && rf_we_q;
  assign fwd_pending = (state == S_WAIT) && rf_we_q;
  assign fwd_waddr   = rf_waddr_q;
  assign fwd_wdata   = result_q;
`ifdef MEM_HILO_EN
  assign wb_hilo_we  = hilo_we_q;
  assign wb_hi       = hi_q;
  assign wb_lo       = lo_q;
`endif

endmodule
